// File: rtl/seg7_bcd_counter_mux.sv
// rtl/seg7_bcd_counter_mux.sv - multi-digit BCD up/down counter with multiplexed 7-segment drive
module seg7_bcd_counter_mux #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 10,
    parameter int SCAN_DIV = 4,
    parameter int LZ_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  run,
    input  logic                  dir,
    input  logic                  clr,
    input  logic                  load,
    input  logic [DIGITS*4-1:0]   load_val,
    output logic [DIGITS*4-1:0]   count_bcd,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig_sel
);

    // Counter widths are kept at least one bit so DIGITS=1 / SCAN_DIV=1 stay legal.
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [PW-1:0]         presc;
    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         scan_idx;
    logic                  tick;
    logic [DIGITS*4-1:0]   count_step;
    logic                  step_wraps;
    logic [DIGITS*4-1:0]   load_clean;
    logic [3:0]            cur_digit;
    logic                  cur_blank;
    logic [DIGITS-1:0]     sel_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign tick = ena & run & (presc == PRESC_LAST);

    // Ripple a +1/-1 through the BCD digits; a carry/borrow out of the top digit is a wrap.
    always_comb begin
        count_step = count_bcd;
        step_wraps = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (step_wraps) begin
                if (dir) begin
                    if (count_bcd[4*i +: 4] == 4'd9) begin
                        count_step[4*i +: 4] = 4'd0;
                    end else begin
                        count_step[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
                        step_wraps = 1'b0;
                    end
                end else begin
                    if (count_bcd[4*i +: 4] == 4'd0) begin
                        count_step[4*i +: 4] = 4'd9;
                    end else begin
                        count_step[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
                        step_wraps = 1'b0;
                    end
                end
            end
        end
    end

    // Non-decimal digits in the load value are forced to 0 so the count stays valid BCD.
    always_comb begin
        load_clean = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] <= 4'd9) begin
                load_clean[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    // Pick the scanned digit and decide whether it is a leading zero.
    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b1;
        sel_next  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == scan_idx) begin
                cur_digit   = count_bcd[4*i +: 4];
                sel_next[i] = 1'b1;
            end
            if ((IW'(i) >= scan_idx) && (count_bcd[4*i +: 4] != 4'd0)) begin
                cur_blank = 1'b0;
            end
        end
        if ((LZ_BLANK == 0) || (scan_idx == '0)) begin
            cur_blank = 1'b0;
        end
    end

    // Prescaler, count and wrap pulse; clr beats load beats tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            count_bcd <= '0;
            wrap      <= 1'b0;
        end else if (ena) begin
            if (clr) begin
                presc     <= '0;
                count_bcd <= '0;
                wrap      <= 1'b0;
            end else if (load) begin
                presc     <= '0;
                count_bcd <= load_clean;
                wrap      <= 1'b0;
            end else begin
                wrap <= tick & step_wraps;
                if (run) begin
                    presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
                end
                if (tick) begin
                    count_bcd <= count_step;
                end
            end
        end
    end

    // Digit scan: each index is held for SCAN_DIV cycles, then advances round-robin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (ena) begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    // Registered display outputs for the currently scanned digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg     <= '0;
            dp      <= 1'b0;
            dig_sel <= '0;
        end else if (ena) begin
            dig_sel <= sel_next;
            seg     <= cur_blank ? 7'b0000000 : decode(cur_digit);
            dp      <= (scan_idx == '0) && (presc < PRESC_HALF);
        end
    end

endmodule

// File: tb/tb_seg7_bcd_counter_mux.sv
// tb/tb_seg7_bcd_counter_mux.sv - self-checking bench for seg7_bcd_counter_mux
module tb_seg7_bcd_counter_mux;

    localparam int D   = 4;
    localparam int TD  = 10;
    localparam int SD  = 4;
    localparam int MAX = 9999;

    logic        clk = 1'b0;
    logic        rst_n, ena, run, dir, clr, load;
    logic [15:0] load_val;
    logic [15:0] count_bcd;
    logic        wrap, dp;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;

    int errors = 0;
    int checks = 0;

    seg7_bcd_counter_mux #(.DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD), .LZ_BLANK(1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .run(run), .dir(dir), .clr(clr),
        .load(load), .load_val(load_val), .count_bcd(count_bcd), .wrap(wrap),
        .seg(seg), .dp(dp), .dig_sel(dig_sel)
    );

    always #5 clk = ~clk;

    logic [6:0] dec_tab [0:9];

    int         m_cnt, m_presc, m_idx, m_scnt;
    logic       m_wrap, m_dp;
    logic [6:0] m_seg;
    logic [3:0] m_sel;

    typedef struct {
        logic [15:0] lv;
        logic [15:0] expect_cnt;
    } load_vec_t;
    load_vec_t lvec [6];

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int bcd2int(input logic [15:0] b);
        int v;
        int d;
        v = 0;
        for (int i = D - 1; i >= 0; i--) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) d = 0;
            v = v * 10 + d;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_presc = 0; m_idx = 0; m_scnt = 0;
        m_wrap = 0; m_dp = 0; m_seg = '0; m_sel = '0;
    endtask

    task automatic model_step();
        int pw;
        int digit;
        if (!rst_n) begin
            model_reset();
        end else if (ena) begin
            pw    = 10 ** m_idx;
            digit = (m_cnt / pw) % 10;
            m_sel = 4'(1 << m_idx);
            m_seg = (m_idx > 0 && m_cnt < pw) ? 7'b0 : dec_tab[digit];
            m_dp  = (m_idx == 0) && (m_presc < TD / 2);
            if (m_scnt == SD - 1) begin
                m_scnt = 0;
                m_idx  = (m_idx + 1) % D;
            end else begin
                m_scnt++;
            end
            m_wrap = 0;
            if (clr) begin
                m_cnt = 0; m_presc = 0;
            end else if (load) begin
                m_cnt = bcd2int(load_val); m_presc = 0;
            end else if (run) begin
                if (m_presc == TD - 1) begin
                    m_presc = 0;
                    if (dir) begin
                        m_wrap = (m_cnt == MAX);
                        m_cnt  = (m_cnt + 1) % (MAX + 1);
                    end else begin
                        m_wrap = (m_cnt == 0);
                        m_cnt  = (m_cnt == 0) ? MAX : m_cnt - 1;
                    end
                end else begin
                    m_presc++;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("count_bcd", 32'(count_bcd), 32'(int2bcd(m_cnt)));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("seg", 32'(seg), 32'(m_seg));
        chk("dp", 32'(dp), 32'(m_dp));
        chk("dig_sel", 32'(dig_sel), 32'(m_sel));
        for (int i = 0; i < D; i++) begin
            chk("bcd_digit_valid", 32'(count_bcd[4*i +: 4] <= 4'd9), 32'd1);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic [3:0] exp_sel [4];
        logic [6:0] exp_seg [4];
        int         budget;

        dec_tab[0] = 7'b0111111; dec_tab[1] = 7'b0000110; dec_tab[2] = 7'b1011011;
        dec_tab[3] = 7'b1001111; dec_tab[4] = 7'b1100110; dec_tab[5] = 7'b1101101;
        dec_tab[6] = 7'b1111101; dec_tab[7] = 7'b0000111; dec_tab[8] = 7'b1111111;
        dec_tab[9] = 7'b1101111;

        lvec[0] = '{16'h12A4, 16'h1204};
        lvec[1] = '{16'h9999, 16'h9999};
        lvec[2] = '{16'hFFFF, 16'h0000};
        lvec[3] = '{16'h0A0B, 16'h0000};
        lvec[4] = '{16'h5678, 16'h5678};
        lvec[5] = '{16'hB001, 16'h0001};

        rst_n = 0; ena = 0; run = 0; dir = 1; clr = 0; load = 0; load_val = '0;
        model_reset();
        cycles(3);
        chk("reset_count", 32'(count_bcd), 32'h0);
        chk("reset_seg", 32'(seg), 32'h0);
        chk("reset_dig_sel", 32'(dig_sel), 32'h0);
        chk("reset_wrap_dp", 32'({wrap, dp}), 32'h0);

        // Counting up from reset: first tick after 10 cycles, 0x0010 after 100
        rst_n = 1; ena = 1; run = 1; dir = 1;
        cycles(9);
        chk("t1_before_tick", 32'(count_bcd), 32'h0000);
        cycle();
        chk("t1_first_tick", 32'(count_bcd), 32'h0001);
        cycles(90);
        chk("t1_hundred", 32'(count_bcd), 32'h0010);

        // Table of load values, including non-decimal digits
        run = 0;
        foreach (lvec[k]) begin
            load = 1; load_val = lvec[k].lv;
            cycle();
            load = 0;
            chk("load_tab", 32'(count_bcd), 32'(lvec[k].expect_cnt));
        end

        // Wrap up then wrap down
        load = 1; load_val = 16'h9999; run = 1; dir = 1;
        cycle();
        load = 0;
        cycles(9);
        chk("t2_pre_wrap", 32'(count_bcd), 32'h9999);
        cycle();
        chk("t2_up_count", 32'(count_bcd), 32'h0000);
        chk("t2_up_wrap", 32'(wrap), 32'd1);
        dir = 0;
        cycle();
        chk("t2_up_wrap_1cyc", 32'(wrap), 32'd0);
        cycles(9);
        chk("t2_down_count", 32'(count_bcd), 32'h9999);
        chk("t2_down_wrap", 32'(wrap), 32'd1);
        cycle();
        chk("t2_down_wrap_1cyc", 32'(wrap), 32'd0);

        // clr coinciding with a wrapping tick: no wrap
        dir = 1; load = 1; load_val = 16'h9999;
        cycle();
        load = 0;
        cycles(9);
        clr = 1;
        cycle();
        clr = 0;
        chk("t3_clr_tick_count", 32'(count_bcd), 32'h0000);
        chk("t3_clr_tick_wrap", 32'(wrap), 32'd0);

        // load coinciding with a tick: load wins
        cycles(9);
        load = 1; load_val = 16'h0500;
        cycle();
        load = 0;
        chk("t3_load_tick", 32'(count_bcd), 32'h0500);

        // Scan sequence on a frozen count of 42
        run = 0; load = 1; load_val = 16'h0042;
        cycle();
        load = 0;
        budget = 0;
        while (dig_sel !== 4'b1000 && budget < 40) begin cycle(); budget++; end
        while (dig_sel !== 4'b0001 && budget < 40) begin cycle(); budget++; end
        chk("t4_scan_found", 32'(budget < 40), 32'd1);
        exp_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_seg = '{7'b1011011, 7'b1100110, 7'b0000000, 7'b0000000};
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < SD; c++) begin
                chk("t4_dig_sel", 32'(dig_sel), 32'(exp_sel[k]));
                chk("t4_seg", 32'(seg), 32'(exp_seg[k]));
                cycle();
            end
        end

        // ena=0 freeze mid-count, then resume at the same prescaler phase
        run = 1; dir = 1;
        cycles(23);
        ena = 0;
        for (int i = 0; i < 50; i++) begin
            clr = (i == 10); load = (i == 20); load_val = 16'h3333;
            cycle();
        end
        clr = 0; load = 0; ena = 1;
        cycles(30);

        // Asynchronous reset between clock edges
        @(posedge clk);
        model_step();
        #2 rst_n = 0;
        #1;
        chk("t6_async_count", 32'(count_bcd), 32'h0);
        chk("t6_async_seg", 32'(seg), 32'h0);
        chk("t6_async_dig_sel", 32'(dig_sel), 32'h0);
        chk("t6_async_wrap_dp", 32'({wrap, dp}), 32'h0);
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1;
        cycles(10);
        chk("t6_restart", 32'(count_bcd), 32'h0001);

        // Randomised traffic against the reference model
        for (int i = 0; i < 2000; i++) begin
            ena      = ($urandom_range(0, 9) != 0);
            run      = ($urandom_range(0, 4) != 0);
            dir      = ($urandom_range(0, 7) != 0) ? dir : ~dir;
            clr      = ($urandom_range(0, 99) < 2);
            load     = ($urandom_range(0, 99) < 3);
            load_val = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'h9995;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
